// File: rtl/i2c_start_stop_det_pkg.sv
// Shared definitions for the I2C slave front end: detector state encoding
// and default deglitch settings.
package i2c_start_stop_det_pkg;

   // 2'b11 is never produced by the detector.
   typedef enum logic [1:0] {
      NULL_DET  = 2'b00,
      START_DET = 2'b01,
      STOP_DET  = 2'b10
   } detState_t;

   localparam int unsigned DEB_LEN_DEFAULT = 3;
   localparam int unsigned CNT_W_DEFAULT   = 4;

endpackage

// File: rtl/i2c_deglitch.sv
// Single-line synchroniser and deglitch filter. The filtered output only
// follows the synchronised line after it has disagreed for DEB_LEN
// consecutive clocks, so shorter pulses are swallowed.
module i2c_deglitch
   import i2c_start_stop_det_pkg::*;
#(
   parameter int unsigned DEB_LEN   = DEB_LEN_DEFAULT,
   parameter int unsigned CNT_W     = CNT_W_DEFAULT,
   parameter logic        RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filtered
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser; resets to the idle level so release causes no edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= RESET_VAL;
         s2 <= RESET_VAL;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Count consecutive disagreements; adopt the new level on the DEB_LEN-th one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         filtered <= RESET_VAL;
      end else if (s2 == filtered) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         filtered <= s2;
         cnt      <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/i2c_start_stop_det.sv
// I2C slave front end: filters SCL/SDA, detects START/STOP on the filtered
// lines, keeps a sticky detection state until cleared, and tracks bus-busy.
module i2c_start_stop_det
   import i2c_start_stop_det_pkg::*;
#(
   parameter int unsigned DEB_LEN = DEB_LEN_DEFAULT,
   parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclRaw,
   input  logic       sdaRaw,
   input  logic       clearStartStopDet,
   output logic       scl,
   output logic       sdaIn,
   output logic [1:0] startStopDetState,
   output logic       busBusy
);

   detState_t detState;
   logic      sclPrev;
   logic      sdaPrev;
   logic      startSeen;
   logic      stopSeen;

   i2c_deglitch #(
      .DEB_LEN   (DEB_LEN),
      .CNT_W     (CNT_W),
      .RESET_VAL (1'b1)
   ) sclFilter (
      .clk      (clk),
      .rst      (rst),
      .raw      (sclRaw),
      .filtered (scl)
   );

   i2c_deglitch #(
      .DEB_LEN   (DEB_LEN),
      .CNT_W     (CNT_W),
      .RESET_VAL (1'b1)
   ) sdaFilter (
      .clk      (clk),
      .rst      (rst),
      .raw      (sdaRaw),
      .filtered (sdaIn)
   );

   // Keep last cycle's filtered levels so SDA edges can be qualified by a steady-high SCL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclPrev <= 1'b1;
         sdaPrev <= 1'b1;
      end else begin
         sclPrev <= scl;
         sdaPrev <= sdaIn;
      end
   end

   // SCL must be high on both sides of the SDA edge; simultaneous SCL/SDA moves are ignored.
   assign startSeen = sclPrev && scl && sdaPrev && !sdaIn;
   assign stopSeen  = sclPrev && scl && !sdaPrev && sdaIn;

   // Sticky detection state; a new event always wins over a clear so nothing is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         detState <= NULL_DET;
         busBusy  <= 1'b0;
      end else if (startSeen) begin
         detState <= START_DET;
         busBusy  <= 1'b1;
      end else if (stopSeen) begin
         detState <= STOP_DET;
         busBusy  <= 1'b0;
      end else if (clearStartStopDet) begin
         detState <= NULL_DET;
      end
   end

   assign startStopDetState = detState;

endmodule

// File: tb/tb_i2c_start_stop_det.sv
// Self-checking bench for i2c_start_stop_det: directed scenarios with
// hand-computed expectations plus a randomized run, all compared every cycle
// against a behavioural model of the filter and START/STOP rules.
module tb_i2c_start_stop_det;

   localparam int DEB_LEN = 3;

   logic       clk;
   logic       rst;
   logic       sclRaw;
   logic       sdaRaw;
   logic       clearStartStopDet;
   logic       scl;
   logic       sdaIn;
   logic [1:0] startStopDetState;
   logic       busBusy;

   int checks = 0;
   int errors = 0;

   i2c_start_stop_det #(.DEB_LEN(DEB_LEN), .CNT_W(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .sclRaw            (sclRaw),
      .sdaRaw            (sdaRaw),
      .clearStartStopDet (clearStartStopDet),
      .scl               (scl),
      .sdaIn             (sdaIn),
      .startStopDetState (startStopDetState),
      .busBusy           (busBusy)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Index 0 = SCL, index 1 = SDA.
   bit         rawPast [2][2];
   bit         win     [2][16];
   int         nWin    [2];
   bit         filt    [2];
   bit         filtPrev[2];
   logic [1:0] mState;
   bit         mBusy;
   bit         mRaw    [2];
   bit         mS2;
   bit         mAllDiff;
   bit         mStart;
   bit         mStop;

   // The filter flips once the last DEB_LEN synchronised samples all disagree with it.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < 2; l++) begin
            rawPast[l][0] = 1'b1;
            rawPast[l][1] = 1'b1;
            nWin[l]       = 0;
            filt[l]       = 1'b1;
            filtPrev[l]   = 1'b1;
         end
         mState = 2'b00;
         mBusy  = 1'b0;
      end else begin
         mStart = filtPrev[0] && filt[0] && filtPrev[1] && !filt[1];
         mStop  = filtPrev[0] && filt[0] && !filtPrev[1] && filt[1];
         if (mStart) begin
            mState = 2'b01;
            mBusy  = 1'b1;
         end else if (mStop) begin
            mState = 2'b10;
            mBusy  = 1'b0;
         end else if (clearStartStopDet) begin
            mState = 2'b00;
         end
         mRaw[0] = sclRaw;
         mRaw[1] = sdaRaw;
         for (int l = 0; l < 2; l++) begin
            mS2           = rawPast[l][1];
            rawPast[l][1] = rawPast[l][0];
            rawPast[l][0] = mRaw[l];
            for (int i = 15; i > 0; i--) win[l][i] = win[l][i-1];
            win[l][0] = mS2;
            if (nWin[l] < 16) nWin[l]++;
            filtPrev[l] = filt[l];
            mAllDiff = (nWin[l] >= DEB_LEN);
            for (int i = 0; i < DEB_LEN; i++) begin
               if (win[l][i] == filt[l]) mAllDiff = 1'b0;
            end
            if (mAllDiff) filt[l] = !filt[l];
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic sclV, input logic sdaV, input logic clrV);
      sclRaw            = sclV;
      sdaRaw            = sdaV;
      clearStartStopDet = clrV;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every cycle, outputs must match the model.
   always @(negedge clk) begin
      checkOutput("model_scl",   {1'b0, scl},     {1'b0, filt[0]});
      checkOutput("model_sdaIn", {1'b0, sdaIn},   {1'b0, filt[1]});
      checkOutput("model_state", startStopDetState, mState);
      checkOutput("model_busy",  {1'b0, busBusy}, {1'b0, mBusy});
   end

   // ---------------- stimulus ----------------
   int  sclHold;
   int  sdaHold;
   bit  sawLow;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitCycles(2);
      rst = 1'b0;

      // Idle bus after reset.
      $display("[TB] idle after reset");
      for (int i = 0; i < 20; i++) begin
         waitCycles(1);
         checkOutput("idle_state", startStopDetState, 2'b00);
         checkOutput("idle_busy", {1'b0, busBusy}, 2'b00);
      end
      checkOutput("idle_scl", {1'b0, scl}, 2'b01);
      checkOutput("idle_sda", {1'b0, sdaIn}, 2'b01);

      // START: sdaIn falls 5 edges after the raw drop, state one edge later.
      $display("[TB] START");
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(4);
      checkOutput("start_sda_not_yet", {1'b0, sdaIn}, 2'b01);
      waitCycles(1);
      checkOutput("start_sda_fell", {1'b0, sdaIn}, 2'b00);
      checkOutput("start_state_not_yet", startStopDetState, 2'b00);
      waitCycles(1);
      checkOutput("start_state", startStopDetState, 2'b01);
      checkOutput("start_busy", {1'b0, busBusy}, 2'b01);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("clear_state", startStopDetState, 2'b00);
      checkOutput("clear_busy_kept", {1'b0, busBusy}, 2'b01);

      // STOP.
      $display("[TB] STOP");
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitCycles(5);
      checkOutput("stop_state_not_yet", startStopDetState, 2'b00);
      waitCycles(1);
      checkOutput("stop_state", startStopDetState, 2'b10);
      checkOutput("stop_busy", {1'b0, busBusy}, 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("stop_clear", startStopDetState, 2'b00);

      // Two-cycle glitch is swallowed.
      $display("[TB] glitch");
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(2);
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         waitCycles(1);
         checkOutput("glitch2_sda", {1'b0, sdaIn}, 2'b01);
         checkOutput("glitch2_state", startStopDetState, 2'b00);
      end

      // Three-cycle pulse passes: START then STOP.
      sawLow = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(3);
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         waitCycles(1);
         if (sdaIn === 1'b0) sawLow = 1'b1;
      end
      checkOutput("pulse3_passed", {1'b0, sawLow}, 2'b01);
      checkOutput("pulse3_state", startStopDetState, 2'b10);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b1, 1'b1, 1'b0);

      // Clear coinciding with START detection loses to the detection.
      $display("[TB] simultaneous");
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(5);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("simul_start_wins", startStopDetState, 2'b01);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(10);
      checkOutput("simul_scl_low", {1'b0, scl}, 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitCycles(10);
      checkOutput("simul_no_stop", startStopDetState, 2'b01);
      checkOutput("simul_busy", {1'b0, busBusy}, 2'b01);

      // Asynchronous reset mid-transfer.
      $display("[TB] async reset");
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(8);
      #2 rst = 1'b1;
      #1;
      checkOutput("areset_state", startStopDetState, 2'b00);
      checkOutput("areset_busy", {1'b0, busBusy}, 2'b00);
      checkOutput("areset_sda", {1'b0, sdaIn}, 2'b01);
      checkOutput("areset_scl", {1'b0, scl}, 2'b01);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitCycles(1);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         waitCycles(1);
         checkOutput("post_reset_state", startStopDetState, 2'b00);
      end

      // Randomized traffic checked by the model each cycle.
      $display("[TB] random");
      sclHold = 0;
      sdaHold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (sclHold == 0) begin
            sclRaw  = 1'($urandom_range(0, 1));
            sclHold = int'($urandom_range(1, 12));
         end
         if (sdaHold == 0) begin
            sdaRaw  = 1'($urandom_range(0, 1));
            sdaHold = int'($urandom_range(1, 8));
         end
         clearStartStopDet = ($urandom_range(0, 5) == 0);
         sclHold--;
         sdaHold--;
         waitCycles(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
